perceptron_engine: RTL and testbench

Parametrised single-neuron perceptron core that replaces the fixed bank/acc/mux datapath with one self-contained, configurable engine. Weights and bias are held internally and loaded by the host controller. Input samples arrive as a valid/ready stream and are MAC'd serially. The engine either reports the classification (infer mode) or also applies the perceptron learning rule (train mode). It sits between the ctrl block (which decodes UART commands) and the UART transmit mux.

---
 rtl/perceptron_engine.sv | 171 +++++++++++++++++
 tb/tb_perceptron_engine.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_engine.sv
// Single-neuron perceptron: serial MAC over a valid/ready input stream, sign decision,
// and an optional perceptron-rule weight update with saturating arithmetic.
module perceptron_engine #(
   parameter  int N_INPUTS  = 8,
   parameter  int W_WIDTH   = 8,
   parameter  int X_WIDTH   = 8,
   localparam int AW        = $clog2(N_INPUTS + 1),
   localparam int ACC_WIDTH = W_WIDTH + X_WIDTH + AW
) (
   input  logic                 clk,
   input  logic                 nRst,
   input  logic                 w_load,
   input  logic [AW-1:0]        w_addr,
   input  logic [W_WIDTH-1:0]   w_data,
   input  logic                 start,
   input  logic                 mode,
   input  logic                 target,
   input  logic                 x_valid,
   input  logic [X_WIDTH-1:0]   x_data,
   output logic                 x_ready,
   output logic                 busy,
   output logic                 done,
   output logic                 y,
   output logic [ACC_WIDTH-1:0] acc,
   output logic [15:0]          err_cnt
);

   localparam int IW = $clog2(N_INPUTS);
   localparam int SW = ((W_WIDTH > X_WIDTH) ? W_WIDTH : X_WIDTH) + 2;
   localparam logic signed [SW-1:0] W_MAX = SW'((2 ** (W_WIDTH - 1)) - 1);
   localparam logic signed [SW-1:0] W_MIN = SW'(-(2 ** (W_WIDTH - 1)));
   localparam logic signed [SW-1:0] ONE   = SW'(1);

   typedef enum logic [2:0] {S_IDLE, S_MAC, S_DECIDE, S_UPDATE, S_DONE} state_t;

   state_t state_q, state_d;

   logic signed [W_WIDTH-1:0]   w_q [N_INPUTS];
   logic signed [W_WIDTH-1:0]   bias_q;
   logic signed [X_WIDTH-1:0]   buf_q [N_INPUTS];
   logic        [AW-1:0]        idx_q;
   logic signed [ACC_WIDTH-1:0] acc_int_q;
   logic signed [ACC_WIDTH-1:0] acc_q;
   logic                        y_q;
   logic                        mode_q;
   logic                        target_q;
   logic        [15:0]          err_cnt_q;

   logic        [IW-1:0]              sel;
   logic signed [X_WIDTH-1:0]         x_s;
   logic signed [W_WIDTH-1:0]         w_data_s;
   logic signed [W_WIDTH+X_WIDTH-1:0] prod;
   logic signed [ACC_WIDTH-1:0]       prod_ext;
   logic signed [X_WIDTH:0]           buf_ext;
   logic signed [X_WIDTH:0]           delta;
   logic signed [SW-1:0]              w_sum;
   logic signed [SW-1:0]              bias_sum;
   logic                              accept;
   logic                              last_elem;
   logic                              last_upd;
   logic                              y_int;
   logic                              mis;

   function automatic logic signed [W_WIDTH-1:0] sat_w(input logic signed [SW-1:0] v);
      if (v > W_MAX)      return W_WIDTH'(W_MAX);
      else if (v < W_MIN) return W_WIDTH'(W_MIN);
      else                return W_WIDTH'(v);
   endfunction

   assign sel       = idx_q[IW-1:0];
   assign x_s       = x_data;
   assign w_data_s  = w_data;
   assign prod      = w_q[sel] * x_s;
   assign prod_ext  = ACC_WIDTH'(prod);
   // Negation at X_WIDTH+1 bits so the most negative input flips to a representable positive.
   assign buf_ext   = (X_WIDTH + 1)'(buf_q[sel]);
   assign delta     = target_q ? buf_ext : -buf_ext;
   assign w_sum     = SW'(w_q[sel]) + SW'(delta);
   assign bias_sum  = SW'(bias_q) + (target_q ? ONE : -ONE);
   assign accept    = x_valid && (state_q == S_MAC);
   assign last_elem = (idx_q == AW'(N_INPUTS - 1));
   assign last_upd  = (idx_q == AW'(N_INPUTS));
   assign y_int     = ~acc_int_q[ACC_WIDTH-1];
   assign mis       = mode_q && (y_int != target_q);

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (start) state_d = S_MAC;
         S_MAC:    if (accept && last_elem) state_d = S_DECIDE;
         S_DECIDE: state_d = mis ? S_UPDATE : S_DONE;
         S_UPDATE: if (last_upd) state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      x_ready = (state_q == S_MAC);
      busy    = (state_q != S_IDLE);
      done    = (state_q == S_DONE);
   end

   assign y       = y_q;
   assign acc     = acc_q;
   assign err_cnt = err_cnt_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         for (int k = 0; k < N_INPUTS; k++) w_q[k] <= '0;
         bias_q    <= '0;
         idx_q     <= '0;
         acc_int_q <= '0;
         acc_q     <= '0;
         y_q       <= 1'b0;
         mode_q    <= 1'b0;
         target_q  <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  mode_q    <= mode;
                  target_q  <= target;
                  acc_int_q <= ACC_WIDTH'(bias_q);
                  idx_q     <= '0;
               end else if (w_load) begin
                  if (w_addr < AW'(N_INPUTS))       w_q[w_addr[IW-1:0]] <= w_data_s;
                  else if (w_addr == AW'(N_INPUTS)) bias_q              <= w_data_s;
               end
            end
            S_MAC: begin
               if (accept) begin
                  acc_int_q <= acc_int_q + prod_ext;
                  idx_q     <= idx_q + AW'(1);
               end
            end
            S_DECIDE: begin
               if (mis) begin
                  if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
                  idx_q <= '0;
               end
            end
            S_UPDATE: begin
               if (last_upd) bias_q   <= sat_w(bias_sum);
               else          w_q[sel] <= sat_w(w_sum);
               idx_q <= idx_q + AW'(1);
            end
            default: ;
         endcase
         // Results are published on entry to DONE so they are valid while done is high.
         if (state_d == S_DONE) begin
            y_q   <= y_int;
            acc_q <= acc_int_q;
         end
      end
   end

   // NOTE: the sample buffer has no reset; its contents are always rewritten before they are read.
   always_ff @(posedge clk) begin
      if (accept) buf_q[sel] <= x_s;
   end

endmodule

// File: tb/tb_perceptron_engine.sv
// Directed bench for perceptron_engine (N_INPUTS=4) with hand-computed expected results.
module tb_perceptron_engine;

   localparam int N  = 4;
   localparam int WW = 8;
   localparam int XW = 8;
   localparam int AW = $clog2(N + 1);
   localparam int AC = WW + XW + AW;

   logic                 clk = 1'b0;
   logic                 nRst = 1'b0;
   logic                 w_load = 1'b0;
   logic [AW-1:0]        w_addr = '0;
   logic [WW-1:0]        w_data = '0;
   logic                 start = 1'b0;
   logic                 mode = 1'b0;
   logic                 target = 1'b0;
   logic                 x_valid = 1'b0;
   logic [XW-1:0]        x_data = '0;
   logic                 x_ready;
   logic                 busy;
   logic                 done;
   logic                 y;
   logic signed [AC-1:0] acc;
   logic [15:0]          err_cnt;

   int n_vec = 0;
   int n_err = 0;
   int lat;

   perceptron_engine #(.N_INPUTS(N), .W_WIDTH(WW), .X_WIDTH(XW)) dut (
      .clk(clk), .nRst(nRst), .w_load(w_load), .w_addr(w_addr), .w_data(w_data),
      .start(start), .mode(mode), .target(target), .x_valid(x_valid), .x_data(x_data),
      .x_ready(x_ready), .busy(busy), .done(done), .y(y), .acc(acc), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_w(input int addr, input int val);
      w_load = 1'b1;
      w_addr = AW'(addr);
      w_data = WW'(val);
      step();
      w_load = 1'b0;
   endtask

   task automatic load_all(input int a, input int b, input int c, input int d, input int bias);
      load_w(0, a);
      load_w(1, b);
      load_w(2, c);
      load_w(3, d);
      load_w(4, bias);
   endtask

   // Runs one sample; returns in the done cycle with the latency counted from the start cycle.
   task automatic run(input logic md, input logic tgt, input int x0, input int x1, input int x2,
                      input int x3, input int gap, input bit inject, input bit wl_start,
                      output int lat_o);
      int xs[4];
      int cyc;
      int guard;
      xs = '{x0, x1, x2, x3};
      mode   = md;
      target = tgt;
      start  = 1'b1;
      if (wl_start) begin
         w_load = 1'b1;
         w_addr = '0;
         w_data = WW'(100);
      end
      step();
      start  = 1'b0;
      w_load = 1'b0;
      cyc    = 1;
      for (int k = 0; k < 4; k++) begin
         x_valid = 1'b1;
         x_data  = XW'(xs[k]);
         if (inject && k == 2) begin
            start  = 1'b1;
            w_load = 1'b1;
            w_addr = '0;
            w_data = WW'(50);
         end
         guard = 0;
         while (!x_ready && guard < 50) begin
            step();
            cyc++;
            guard++;
         end
         step();
         cyc++;
         x_valid = 1'b0;
         start   = 1'b0;
         w_load  = 1'b0;
         if (k < 3) repeat (gap) begin
            step();
            cyc++;
         end
      end
      guard = 0;
      while (!done && guard < 50) begin
         step();
         cyc++;
         guard++;
      end
      if (!done) check("done_timeout", 0, 1);
      lat_o = cyc;
   endtask

   initial begin
      #12;
      check("rst_busy", busy, 0);
      check("rst_xready", x_ready, 0);
      check("rst_done", done, 0);
      check("rst_y", y, 0);
      check("rst_acc", acc, 0);
      check("rst_err", err_cnt, 0);
      nRst = 1'b1;
      step();

      // Zero weights: acc = 0, y = 1
      run(0, 0, 1, 2, 3, 4, 0, 0, 0, lat);
      check("t1_acc", acc, 0);
      check("t1_y", y, 1);
      check("t1_lat", lat, 6);
      step();
      check("t1_busy_after", busy, 0);
      check("t1_done_pulse", done, 0);

      // 5 - 3 + 2 + 0 - 3 = 1
      load_all(1, -1, 2, 0, -3);
      run(0, 0, 5, 3, 1, 7, 0, 0, 0, lat);
      check("t2_acc", acc, 1);
      check("t2_y", y, 1);
      check("t2_err", err_cnt, 0);
      check("t2_lat", lat, 6);
      step();
      run(0, 0, 5, 3, 1, 7, 0, 0, 0, lat);
      check("t2_reinfer_acc", acc, 1);
      step();

      // Train target 0 while y = 1: w -= x, bias -= 1
      run(1, 0, 5, 3, 1, 7, 0, 0, 0, lat);
      check("t3_y", y, 1);
      check("t3_acc", acc, 1);
      check("t3_err", err_cnt, 1);
      check("t3_lat", lat, 11);
      step();
      run(0, 0, 5, 3, 1, 7, 0, 0, 0, lat);
      check("t3_reinfer_acc", acc, -84);
      check("t3_reinfer_y", y, 0);
      step();

      // 12000 - 16256 - 100 = -4356; w0 -> sat(220)=127, w1 -> -1, bias -> -99
      load_all(120, -128, 0, 0, -100);
      run(1, 1, 100, 127, 0, 0, 0, 0, 0, lat);
      check("t4_acc", acc, -4356);
      check("t4_y", y, 0);
      check("t4_err", err_cnt, 2);
      step();
      run(0, 0, 1, 0, 0, 0, 0, 0, 0, lat);
      check("t4_w0_sat", acc, 28);
      step();
      run(0, 0, 0, 1, 0, 0, 0, 0, 0, lat);
      check("t4_w1", acc, -100);
      step();

      // x0 = -128 with target 0: delta = +128, w0 0 -> sat(128)=127, bias -> -1
      load_all(0, 0, 0, 0, 0);
      run(1, 0, -128, 0, 0, 0, 0, 0, 0, lat);
      check("t4b_y", y, 1);
      check("t4b_err", err_cnt, 3);
      step();
      run(0, 0, 1, 0, 0, 0, 0, 0, 0, lat);
      check("t4b_negsat", acc, 126);
      step();

      // Stalls, mid-MAC start/w_load, start+w_load in IDLE
      load_all(1, -1, 2, 0, -3);
      run(0, 0, 5, 3, 1, 7, 3, 0, 0, lat);
      check("t5_gap_acc", acc, 1);
      check("t5_gap_lat", lat, 15);
      step();
      run(0, 0, 5, 3, 1, 7, 0, 1, 0, lat);
      check("t5_inject_acc", acc, 1);
      check("t5_inject_lat", lat, 6);
      step();
      run(0, 0, 5, 3, 1, 7, 0, 0, 1, lat);
      check("t5_wlstart_acc", acc, 1);
      step();
      run(0, 0, 5, 3, 1, 7, 0, 0, 0, lat);
      check("t5_w0_kept", acc, 1);
      check("t5_err_kept", err_cnt, 3);
      step();

      // Asynchronous reset after two MAC elements
      mode  = 1'b0;
      start = 1'b1;
      step();
      start   = 1'b0;
      x_valid = 1'b1;
      x_data  = XW'(1);
      step();
      x_data  = XW'(2);
      step();
      x_valid = 1'b0;
      #2 nRst = 1'b0;
      #1;
      check("t6_busy", busy, 0);
      check("t6_xready", x_ready, 0);
      check("t6_y", y, 0);
      check("t6_acc", acc, 0);
      check("t6_err", err_cnt, 0);
      #10 nRst = 1'b1;
      step();
      // Old weights would give 2; cleared weights give 0
      run(0, 0, 1, 2, 3, 4, 0, 0, 0, lat);
      check("t6_fresh_acc", acc, 0);
      check("t6_fresh_y", y, 1);
      check("t6_fresh_lat", lat, 6);
      step();

      force dut.err_cnt_q = 16'hFFFF;
      step();
      release dut.err_cnt_q;
      run(1, 0, 1, 2, 3, 4, 0, 0, 0, lat);
      check("t6_err_sat", err_cnt, 65535);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
